// File: rtl/ecc_pkg.sv
// Shared SEC-DED definitions for ENC/ecc_dec: modes, per-mode widths, H columns.
// Codeword layout: bit 0 overall parity, bits at powers of two Hamming parity, info elsewhere.
package ecc_pkg;

  typedef enum logic [1:0] {
    MOD_ILLEGAL = 2'b00,
    MOD_1       = 2'b01,
    MOD_2       = 2'b10,
    MOD_3       = 2'b11
  } mode_t;

  localparam int MAX_CW_W   = 32;
  localparam int MAX_INFO_W = 26;
  localparam int MAX_PAR_W  = 6;

  // Indexed by mode_t; the MOD_ILLEGAL slot is zero.
  localparam logic [3:0][5:0] CW_W     = {6'd32, 6'd16, 6'd8, 6'd0};
  localparam logic [3:0][5:0] INFO_W   = {6'd26, 6'd11, 6'd4, 6'd0};
  localparam logic [3:0][5:0] PARITY_W = {6'd6,  6'd5,  6'd4, 6'd0};

  typedef logic [MAX_CW_W-1:0][MAX_PAR_W-1:0] h_t;

  // Column j is {overall-parity row, position j}; columns at or above n are zero.
  function automatic h_t gen_h(input int p, input int n);
    h_t h;
    h = '0;
    for (int j = 0; j < n; j++) begin
      h[j] = 6'((1 << (p - 1)) | j);
    end
    return h;
  endfunction

  localparam h_t H_MOD1 = gen_h(4, 8);
  localparam h_t H_MOD2 = gen_h(5, 16);
  localparam h_t H_MOD3 = gen_h(6, 32);

  function automatic logic is_pow2(input int j);
    return (j > 0) && ((j & (j - 1)) == 0);
  endfunction

  // Info bit index for codeword bit j; only meaningful where j is an info position.
  function automatic int info_idx(input int j);
    int c;
    c = 0;
    for (int b = 0; b < MAX_PAR_W; b++) begin
      if ((1 << b) <= j) c++;
    end
    if (j == 0 || is_pow2(j)) return 0;
    return j - c - 1;
  endfunction

endpackage

// File: rtl/ecc_dec_syndrome.sv
// Combinational syndrome and single-error locator for one received codeword.
// Bits above the mode's codeword width never enter the syndrome.
module ecc_dec_syndrome
  import ecc_pkg::*;
(
  input  logic [MAX_CW_W-1:0]  r,
  input  mode_t                mod,
  output logic [MAX_PAR_W-1:0] s,
  output logic [4:0]           err_pos,
  output logic                 pos_valid
);

  h_t                h;
  logic [5:0]        n_cw;
  logic [MAX_CW_W-1:0] match;

  always_comb begin
    case (mod)
      MOD_1:   h = H_MOD1;
      MOD_2:   h = H_MOD2;
      MOD_3:   h = H_MOD3;
      default: h = '0;
    endcase
    n_cw = CW_W[mod];

    s = '0;
    for (int j = 0; j < MAX_CW_W; j++) begin
      if (j < int'(n_cw) && r[j]) s = s ^ h[j];
    end

    // Columns are distinct, so at most one bit of match is set and an OR suffices.
    match   = '0;
    err_pos = '0;
    for (int j = 0; j < MAX_CW_W; j++) begin
      match[j] = (j < int'(n_cw)) && (s == h[j]);
      if (match[j]) err_pos = err_pos | 5'(j);
    end
    pos_valid = |match;
  end

endmodule

// File: rtl/ecc_dec.sv
// SEC-DED decoder for (8,4)/(16,11)/(32,26): corrects 1 error, flags 2, one word per clk.
// Latency 2 clk valid_in -> valid_out; no backpressure, outputs hold across bubbles.
module ecc_dec
  import ecc_pkg::*;
#(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
  input  logic [1:0]                    mod,
  input  logic                          valid_in,
  output logic [MAX_INFO_WIDTH-1:0]     data_out,
  output logic [1:0]                    num_of_errors,
  output logic                          valid_out
);

  logic [MAX_CODEWORD_WIDTH-1:0] r1;
  mode_t                         mod1;
  logic                          vld1;

  logic [MAX_PAR_W-1:0]          s;
  logic [4:0]                    err_pos;
  logic                          pos_valid;
  logic                          overall;

  logic [MAX_CODEWORD_WIDTH-1:0] rc;
  logic [MAX_INFO_WIDTH-1:0]     info_d;
  logic [1:0]                    nerr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1   <= '0;
      mod1 <= MOD_ILLEGAL;
      vld1 <= 1'b0;
    end else begin
      vld1 <= valid_in;
      if (valid_in) begin
        r1   <= data_in;
        mod1 <= mode_t'(mod);
      end
    end
  end

  ecc_dec_syndrome u_syndrome (
    .r         (r1),
    .mod       (mod1),
    .s         (s),
    .err_pos   (err_pos),
    .pos_valid (pos_valid)
  );

  always_comb begin
    case (mod1)
      MOD_1:   overall = s[3];
      MOD_2:   overall = s[4];
      MOD_3:   overall = s[5];
      default: overall = 1'b0;
    endcase
  end

  always_comb begin
    rc     = r1;
    info_d = '0;
    if (mod1 == MOD_ILLEGAL) begin
      nerr_d = 2'd3;
    end else if (s == '0) begin
      nerr_d = 2'd0;
    end else if (overall && pos_valid) begin
      nerr_d      = 2'd1;
      rc[err_pos] = ~rc[err_pos];
    end else begin
      nerr_d = 2'd2;
    end

    // Illegal mode has CW_W of zero, so nothing is extracted and data_out stays 0.
    for (int j = 1; j < MAX_CW_W; j++) begin
      if (!is_pow2(j) && j < int'(CW_W[mod1])) info_d[5'(info_idx(j))] = rc[j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out      <= '0;
      num_of_errors <= 2'd0;
      valid_out     <= 1'b0;
    end else begin
      valid_out <= vld1;
      if (vld1) begin
        data_out      <= info_d;
        num_of_errors <= nerr_d;
      end
    end
  end

endmodule

// File: tb/tb_ecc_dec.sv
// Bench for ecc_dec: directed cases plus random mixed-mode traffic against a
// position-arithmetic SEC-DED model with a 2-cycle expectation queue.
module tb_ecc_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [1:0]  mod;
  logic        valid_in;
  logic [25:0] data_out;
  logic [1:0]  num_of_errors;
  logic        valid_out;

  always #5 clk = ~clk;

  ecc_dec dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .mod           (mod),
    .valid_in      (valid_in),
    .data_out      (data_out),
    .num_of_errors (num_of_errors),
    .valid_out     (valid_out)
  );

  typedef struct {
    logic        vld;
    logic [25:0] d;
    logic [1:0]  n;
  } exp_t;

  exp_t        q[$];
  logic [25:0] last_d;
  logic [1:0]  last_n;
  int          errors = 0;
  int          checks = 0;
  string       tag;

  function automatic int cw_n(input int m);
    return 4 << m;
  endfunction

  function automatic logic [31:0] enc(input int m, input logic [25:0] info);
    logic [31:0] cw;
    int          idx;
    int          n;
    logic        p;
    cw  = '0;
    idx = 0;
    n   = cw_n(m);
    for (int pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = info[idx];
        idx++;
      end
    end
    for (int i = 0; (1 << i) < n; i++) begin
      p = 1'b0;
      for (int pos = 1; pos < n; pos++) begin
        if (((pos >> i) & 1) == 1) p = p ^ cw[pos];
      end
      cw[1 << i] = p;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  // Syndrome = XOR of positions of set bits; overall parity decides 1 vs 2 errors.
  function automatic exp_t model(input logic v, input logic [1:0] m, input logic [31:0] d);
    exp_t        e;
    logic [31:0] r;
    int          n;
    int          syn;
    int          idx;
    logic        ov;
    e.vld = v;
    e.d   = '0;
    e.n   = 2'd0;
    if (m == 2'd0) begin
      e.n = 2'd3;
      return e;
    end
    n   = cw_n(int'(m));
    r   = '0;
    syn = 0;
    for (int j = 0; j < n; j++) begin
      r[j] = d[j];
      if (d[j]) syn = syn ^ j;
    end
    ov = ^r;
    if (ov) begin
      r[syn] = ~r[syn];
      e.n    = 2'd1;
    end else if (syn != 0) begin
      e.n = 2'd2;
    end
    idx = 0;
    for (int pos = 1; pos < n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        e.d[idx] = r[pos];
        idx++;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_out(input logic v, input logic [25:0] d, input logic [1:0] n);
    check({tag, ".valid_out"}, 32'(valid_out), 32'(v));
    check({tag, ".data_out"}, 32'(data_out), 32'(d));
    check({tag, ".num_of_errors"}, 32'(num_of_errors), 32'(n));
  endtask

  // One clock: check outputs against the word sent two cycles ago, then drive the next input.
  task automatic tick(input logic v, input logic [1:0] m, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    e.vld = 1'b0;
    e.d   = '0;
    e.n   = 2'd0;
    if (q.size() >= 2) e = q.pop_front();
    if (e.vld) begin
      last_d = e.d;
      last_n = e.n;
    end
    expect_out(e.vld, last_d, last_n);
    valid_in = v;
    mod      = m;
    data_in  = d;
    q.push_back(model(v, m, d));
  endtask

  task automatic idle();
    tick(1'b0, 2'($urandom), $urandom);
  endtask

  initial begin
    logic [31:0] w;
    int          m;
    int          n;
    int          b1;
    int          b2;

    rst      = 1'b1;
    valid_in = 1'b0;
    mod      = 2'd0;
    data_in  = '0;
    last_d   = '0;
    last_n   = 2'd0;
    #1 rst = 1'b0;
    #2;
    tag = "reset";
    expect_out(1'b0, 26'h0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    tag = "clean_m1";
    tick(1'b1, 2'd1, enc(1, 26'hB));
    idle();
    idle();
    expect_out(1'b1, 26'h00000B, 2'd0);

    tag = "single_m2";
    for (int b = 0; b < 16; b++) begin
      tick(1'b1, 2'd2, enc(2, 26'h5A3) ^ (32'd1 << b));
      idle();
      idle();
      expect_out(1'b1, 26'h0005A3, 2'd1);
    end

    tag = "double_m3";
    tick(1'b1, 2'd3, enc(3, 26'h3FFFFFF) ^ 32'h0002_0001);
    idle();
    idle();
    expect_out(1'b1, 26'h3FFF7FF, 2'd2);

    tag = "b2b_mixed";
    for (int i = 0; i < 10; i++) begin
      m  = (i % 3) + 1;
      n  = cw_n(m);
      b1 = $urandom_range(0, n - 1);
      tick(1'b1, 2'(m), enc(m, 26'($urandom)) ^ (32'd1 << b1));
    end
    idle();
    idle();

    tag = "illegal";
    tick(1'b1, 2'd0, $urandom);
    idle();
    idle();
    expect_out(1'b1, 26'h0, 2'd3);

    tag = "garbage_m1";
    tick(1'b1, 2'd1, 32'hFFFF_FF00 | enc(1, 26'hB));
    idle();
    idle();
    expect_out(1'b1, 26'h00000B, 2'd0);

    tag = "reset_mid";
    tick(1'b1, 2'd2, enc(2, 26'h123));
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b0;
    #1;
    expect_out(1'b0, 26'h0, 2'd0);
    q.delete();
    last_d = '0;
    last_n = 2'd0;
    @(negedge clk);
    expect_out(1'b0, 26'h0, 2'd0);
    rst = 1'b1;
    idle();
    idle();
    idle();
    tick(1'b1, 2'd1, enc(1, 26'h5));
    idle();
    idle();
    expect_out(1'b1, 26'h000005, 2'd0);

    tag = "random";
    for (int i = 0; i < 300; i++) begin
      m = $urandom_range(0, 3);
      if (m == 0) begin
        w = $urandom;
      end else begin
        n  = cw_n(m);
        w  = enc(m, 26'($urandom));
        b1 = $urandom_range(0, n - 1);
        b2 = (b1 + 1 + $urandom_range(0, n - 2)) % n;
        case ($urandom_range(0, 2))
          0:       ;
          1:       w = w ^ (32'd1 << b1);
          default: w = w ^ (32'd1 << b1) ^ (32'd1 << b2);
        endcase
        if ($urandom_range(0, 1) == 1) w = w | ($urandom << n);
      end
      tick($urandom_range(0, 3) != 0, 2'(m), w);
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
